icache_fill_control: RTL

ICACHE_FILL_CONTROL -- requirements
Module: icache_fill_control

---
 rtl/icache_fill_control.sv | 131 +++++++++++++
 1 files changed

// File: rtl/icache_fill_control.sv
// Instruction-cache fill controller: hit responses, round-robin line fills, set-by-set flush.
// Latency: hit responds in the request cycle; miss responds one cycle after the last of WORDS_PER_LINE beats.
// Backpressure: fetch holds its request until responded; memory beats may arrive with gaps, fill waits for them.
module icache_fill_control #(
    parameter int NUM_WAYS       = 4,
    parameter int NUM_SETS       = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ifetch_icache_read,
    input  logic [$clog2(NUM_SETS)-1:0]       ifetch_set,
    input  logic                              icache_hit,
    output logic                              icache_ifetch_resp,
    output logic                              icache_iddr_read,
    input  logic                              iddr_icache_resp,
    output logic [NUM_WAYS-1:0]               icache_load,
    output logic [$clog2(WORDS_PER_LINE)-1:0] icache_word_sel,
    input  logic                              icache_flush,
    output logic                              icache_valid_clear,
    output logic [$clog2(NUM_SETS)-1:0]       icache_flush_set
);
    localparam int SW = $clog2(NUM_SETS);
    localparam int WW = $clog2(NUM_WAYS);
    localparam int BW = $clog2(WORDS_PER_LINE);
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);
    localparam logic [SW-1:0] LAST_SET  = SW'(NUM_SETS - 1);

    typedef enum logic [1:0] {IDLE, FILL, RESP, FLUSH} state_t;

    state_t         state;
    logic [BW-1:0]  beat_cnt;
    logic [SW-1:0]  fill_set;
    logic [WW-1:0]  fill_way;
    logic [SW-1:0]  flush_cnt;
    logic           flush_pend;
    logic [WW-1:0]  rr_ptr [NUM_SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            fill_set   <= '0;
            fill_way   <= '0;
            flush_cnt  <= '0;
            flush_pend <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (icache_flush) begin
                        flush_cnt <= '0;
                        state     <= FLUSH;
                    end else if (ifetch_icache_read && !icache_hit) begin
                        fill_set <= ifetch_set;
                        fill_way <= rr_ptr[ifetch_set];
                        beat_cnt <= '0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (icache_flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (iddr_icache_resp) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            rr_ptr[fill_set] <= rr_ptr[fill_set] + 1'b1;
                            state            <= RESP;
                        end
                    end
                end
                RESP: begin
                    // A flush arriving in the response cycle is deferred the same way as one seen during fill.
                    if (flush_pend || icache_flush) begin
                        flush_cnt <= '0;
                        state     <= FLUSH;
                    end else begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    rr_ptr[flush_cnt] <= '0;
                    flush_cnt         <= flush_cnt + 1'b1;
                    if (flush_cnt == LAST_SET) begin
                        flush_pend <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs follow the current-cycle inputs, so they are decoded combinationally and forced low during reset.
    always_comb begin
        icache_ifetch_resp = 1'b0;
        icache_iddr_read   = 1'b0;
        icache_load        = '0;
        icache_word_sel    = '0;
        icache_valid_clear = 1'b0;
        icache_flush_set   = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!icache_flush && ifetch_icache_read) begin
                        icache_ifetch_resp = icache_hit;
                        icache_iddr_read   = !icache_hit;
                    end
                end
                FILL: begin
                    icache_iddr_read = 1'b1;
                    if (iddr_icache_resp) begin
                        icache_load     = {{(NUM_WAYS-1){1'b0}}, 1'b1} << fill_way;
                        icache_word_sel = beat_cnt;
                    end
                end
                RESP: begin
                    icache_ifetch_resp = ifetch_icache_read;
                end
                FLUSH: begin
                    icache_valid_clear = 1'b1;
                    icache_flush_set   = flush_cnt;
                end
                default: ;
            endcase
        end
    end
endmodule
